axi_dma_rd: RTL and testbench
=============================

AXI_DMA_RD -- requirements
Module: axi_dma_rd

Interface
REQ-001 SHALL have parameters: MAX_OUTSTANDING, default 4, the maximum number of AR bursts in flight; BURST_BYTES, default 4096, the bytes per burst (256 beats x 16 B).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first.
- axi_aclk  in  1  sole clock for the AXI master and the AXIS master.
- axi_rst  in  1  reset, asynchronous and active-high.
- axi_araddr/arlen/arsize/arburst/arcache/arprot/arid/aruser  out  32/8/3/2/4/3/4/4  AXI4 read-address channel.
- axi_arvalid  out  1; axi_arready  in  1.
- axi_rdata  in  128; axi_rresp  in  2; axi_rlast  in  1; axi_rvalid  in  1; axi_rready  out  1.
- axis_tdata  out  128; axis_tkeep  out  16; axis_tlast  out  1; axis_tvalid  out  1; axis_tready  in  1.
- read_start  in  1  single-cycle pulse that starts a read.
- read_reset  in  1  synchronous abort/clear.
- continuous  in  1  repeat the buffer until this input drops.
- start_address  in  32  buffer base address.
- cap_size  in  32  buffer length in bytes.
- current_addr  out  32; run_cycles  out  8; rd_err  out  1; cap_done  out  1; busy  out  1.

Function
REQ-003 SHALL latch base = {start_address[31:12],12'h0} and nburst = cap_size[31:12] on read_start accepted in IDLE. cap_size[11:0] SHALL be ignored.
REQ-004 SHALL have FSM states IDLE, RUN, DRAIN, FLUSH, DONE.
REQ-005 State transitions SHALL be:
- IDLE->RUN on read_start with nburst!=0.
- RUN->DRAIN after the last AR handshake of a pass when continuous=0.
- DRAIN->DONE when outstanding==0.
- DONE->IDLE on read_reset.
REQ-006 read_start SHALL be ignored outside IDLE. read_start with nburst==0 SHALL set rd_err and remain in IDLE.
REQ-007 The AR channel SHALL drive constant fields: arlen=255, arsize=3'b100, arburst=2'b01, arcache=4'b0011, arprot=0, arid=0, aruser=0.
REQ-008 axi_arvalid SHALL be high only in RUN with outstanding<MAX_OUTSTANDING. araddr SHALL stay stable until arready.
REQ-009 araddr SHALL advance by BURST_BYTES per AR handshake using 32-bit wrapping arithmetic. After burst nburst-1 with continuous=1, araddr SHALL wrap to base and the FSM SHALL stay in RUN.
REQ-010 The outstanding counter SHALL increment on AR handshake and decrement on a beat with rvalid&rready&rlast. A simultaneous increment and decrement SHALL leave it unchanged.
REQ-011 In RUN and DRAIN the data path SHALL be pass-through: axis_tdata=axi_rdata, axis_tkeep=16'hFFFF, axis_tvalid=axi_rvalid, axi_rready=axis_tready. This adds zero cycles of latency.
REQ-012 axis_tlast SHALL be asserted on the rlast beat of the final burst of each pass. This SHALL be tracked by an R-side burst counter independent of the AR side.
REQ-013 On each pass-end tlast beat, run_cycles SHALL increment, wrapping 255->0.
REQ-014 On the tlast beat that completes the final pass, cap_done SHALL be set to 1 and SHALL stay set until read_reset.
REQ-015 current_addr SHALL load axi_araddr on every AR handshake.
REQ-016 rd_err SHALL be sticky-set on any R beat with rresp!=2'b00. Transfers SHALL continue after the error.
REQ-017 read_reset SHALL take priority over every other event, including a same-cycle read_start. It SHALL clear cap_done, rd_err, run_cycles and current_addr.
REQ-018 On read_reset, the FSM SHALL go to IDLE when outstanding==0 and to FLUSH otherwise.
REQ-019 In FLUSH: arvalid=0, axi_rready=1, axis_tvalid=0. R beats SHALL be discarded until outstanding==0, then the FSM SHALL go to IDLE.
REQ-020 busy SHALL be 1 in RUN, DRAIN and FLUSH.

Reset
REQ-021 While axi_rst is high: FSM=IDLE, all counters=0, arvalid=0, rready=0, axis_tvalid=0, cap_done=0, rd_err=0, busy=0, current_addr=0, run_cycles=0.
REQ-022 Reset asserted mid-burst SHALL drop all valids immediately. Recovery from the interconnect side is handled at system level.

Structure
REQ-023 AXI constants (BURST_INCR, SIZE_16B, CACHE_BUF, RESP_OKAY) and the FSM state encoding SHALL live in package axi_dma_pkg, shared with the write path.
REQ-024 One sub-module, axi_dma_rd_ar_gen (AR issue, address wrap, outstanding counter), SHALL be used. The FSM and the R-side logic SHALL stay at the top level.

Verification
REQ-025 Verification SHALL cover at least these directed scenarios:
- start_address=0x1000_0000, cap_size=0x4000, continuous=0, axis_tready=1 -> 4 ARs at 0x1000_0000/1000/2000/3000; 1024 beats; one tlast, on beat 1024; cap_done=1; run_cycles=1.
- Same setup with arready stalled for 10 cycles -> at most 4 outstanding bursts; araddr held stable throughout the stall.
- continuous=1 for 3 passes, then dropped -> araddr wraps to base after 0x1000_3000; tlast three times; run_cycles=3; cap_done set only after pass 3.
- axis_tready toggling 50% -> rready mirrors tready; no beat lost or duplicated (check with an incrementing-data memory model).
- read_reset with 2 bursts outstanding -> FLUSH; 512 beats discarded with tvalid=0; then IDLE; busy=0; all status cleared.
- rresp=2'b10 on one beat; separately cap_size=0x0800 with read_start -> rd_err=1 in both cases; no AR issued in the second case.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared AXI constants and FSM encoding for the DMA read and write paths.
// Packs the fixed AR/AW field values and the common controller state set.
package axi_dma_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_16B   = 3'b100;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_256    = 8'd255;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic state_busy(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_DRAIN) || (st == ST_FLUSH);
    endfunction

    function automatic logic state_stream(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/axi_dma_rd_ar_gen.sv
// AR issue engine: walks the buffer one burst at a time, wraps to the base
// after the last burst of a pass and tracks bursts still awaiting data.
module axi_dma_rd_ar_gen
    import axi_dma_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_BYTES     = 4096,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      load_base,
    input  logic [19:0]      load_nburst,
    input  logic             arready,
    input  logic             r_done,
    output logic [31:0]      araddr,
    output logic             arvalid,
    output logic             ar_hs,
    output logic             ar_pass_end,
    output logic [19:0]      nburst,
    output logic [OUT_W-1:0] outstanding,
    output logic [OUT_W-1:0] outstanding_next
);

    localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      BURST_INC = 32'(BURST_BYTES);

    logic [31:0]      base_q, base_d;
    logic [19:0]      nburst_q, nburst_d;
    logic [31:0]      addr_q, addr_d;
    logic [19:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;

    assign arvalid     = run && (out_q < MAX_OUT);
    assign ar_hs       = arvalid && arready;
    assign ar_pass_end = ar_hs && (cnt_q == nburst_q - 20'd1);

    always_comb begin
        base_d   = base_q;
        nburst_d = nburst_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            addr_d = base_q;
            cnt_d  = '0;
        end else if (load) begin
            base_d   = load_base;
            nburst_d = load_nburst;
            addr_d   = load_base;
            cnt_d    = '0;
        end else if (ar_hs) begin
            // The last burst of a pass rewinds so a continuous run re-reads the buffer
            if (ar_pass_end) begin
                addr_d = base_q;
                cnt_d  = '0;
            end else begin
                addr_d = addr_q + BURST_INC;
                cnt_d  = cnt_q + 20'd1;
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (ar_hs && !r_done) begin
            out_d = out_q + 1'b1;
        end else if (!ar_hs && r_done && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            nburst_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            base_q   <= base_d;
            nburst_q <= nburst_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign araddr           = addr_q;
    assign nburst           = nburst_q;
    assign outstanding      = out_q;
    assign outstanding_next = out_d;

endmodule

// File: rtl/axi_dma_rd.sv
// AXI4 read DMA: streams a 4 KiB-aligned buffer out of an AXI master onto an
// AXIS master, once or repeatedly, with abort/flush and sticky status.
module axi_dma_rd
    import axi_dma_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_BYTES     = 4096
) (
    input  logic         axi_aclk,
    input  logic         axi_rst,
    output logic [31:0]  axi_araddr,
    output logic [7:0]   axi_arlen,
    output logic [2:0]   axi_arsize,
    output logic [1:0]   axi_arburst,
    output logic [3:0]   axi_arcache,
    output logic [2:0]   axi_arprot,
    output logic [3:0]   axi_arid,
    output logic [3:0]   axi_aruser,
    output logic         axi_arvalid,
    input  logic         axi_arready,
    input  logic [127:0] axi_rdata,
    input  logic [1:0]   axi_rresp,
    input  logic         axi_rlast,
    input  logic         axi_rvalid,
    output logic         axi_rready,
    output logic [127:0] axis_tdata,
    output logic [15:0]  axis_tkeep,
    output logic         axis_tlast,
    output logic         axis_tvalid,
    input  logic         axis_tready,
    input  logic         read_start,
    input  logic         read_reset,
    input  logic         continuous,
    input  logic [31:0]  start_address,
    input  logic [31:0]  cap_size,
    output logic [31:0]  current_addr,
    output logic [7:0]   run_cycles,
    output logic         rd_err,
    output logic         cap_done,
    output logic         busy
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]       state_q, state_d;
    logic [19:0]      r_burst_q, r_burst_d;
    logic [7:0]       run_cycles_q, run_cycles_d;
    logic             cap_done_q, cap_done_d;
    logic             rd_err_q, rd_err_d;
    logic [31:0]      current_addr_q, current_addr_d;

    logic [31:0]      start_base;
    logic [19:0]      start_nburst;
    logic             start_ok;
    logic             start_bad;
    logic             stream;
    logic             r_hs;
    logic             r_done;
    logic             pass_end_beat;
    logic             ar_hs;
    logic             ar_pass_end;
    logic [19:0]      nburst;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_next;
    logic             unused_bits;

    assign unused_bits  = ^{start_address[11:0], cap_size[11:0]};
    assign start_base   = {start_address[31:12], 12'h000};
    assign start_nburst = cap_size[31:12];
    assign start_ok     = (state_q == ST_IDLE) && read_start && !read_reset && (start_nburst != '0);
    assign start_bad    = (state_q == ST_IDLE) && read_start && !read_reset && (start_nburst == '0);

    axi_dma_rd_ar_gen #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BURST_BYTES     (BURST_BYTES),
        .OUT_W           (OUT_W)
    ) u_ar_gen (
        .clk              (axi_aclk),
        .rst              (axi_rst),
        .load             (start_ok),
        .clear            (read_reset),
        .run              (state_q == ST_RUN),
        .load_base        (start_base),
        .load_nburst      (start_nburst),
        .arready          (axi_arready),
        .r_done           (r_done),
        .araddr           (axi_araddr),
        .arvalid          (axi_arvalid),
        .ar_hs            (ar_hs),
        .ar_pass_end      (ar_pass_end),
        .nburst           (nburst),
        .outstanding      (outstanding),
        .outstanding_next (outstanding_next)
    );

    assign axi_arlen   = LEN_256;
    assign axi_arsize  = SIZE_16B;
    assign axi_arburst = BURST_INCR;
    assign axi_arcache = CACHE_BUF;
    assign axi_arprot  = 3'b000;
    assign axi_arid    = 4'h0;
    assign axi_aruser  = 4'h0;

    // Zero-latency pass-through; FLUSH sinks beats without presenting them
    assign stream        = state_stream(state_q);
    assign axis_tdata    = axi_rdata;
    assign axis_tkeep    = stream ? 16'hFFFF : 16'h0000;
    assign axis_tvalid   = stream && axi_rvalid;
    assign axi_rready    = (state_q == ST_FLUSH) || (stream && axis_tready);
    assign axis_tlast    = stream && axi_rlast && (r_burst_q == nburst - 20'd1);
    assign r_hs          = axi_rvalid && axi_rready;
    assign r_done        = r_hs && axi_rlast;
    assign pass_end_beat = axis_tvalid && axis_tready && axis_tlast;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (ar_pass_end && !continuous) state_d = ST_DRAIN;
            ST_DRAIN: if (outstanding == '0) state_d = ST_DONE;
            ST_FLUSH: if (outstanding == '0) state_d = ST_IDLE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        // Decide on the post-edge count so an AR accepted this cycle is still flushed
        if (read_reset) begin
            state_d = (outstanding_next == '0) ? ST_IDLE : ST_FLUSH;
        end
    end

    always_comb begin
        r_burst_d      = r_burst_q;
        run_cycles_d   = run_cycles_q;
        cap_done_d     = cap_done_q;
        rd_err_d       = rd_err_q;
        current_addr_d = current_addr_q;
        if (read_reset) begin
            r_burst_d      = '0;
            run_cycles_d   = '0;
            cap_done_d     = 1'b0;
            rd_err_d       = 1'b0;
            current_addr_d = '0;
        end else begin
            if (start_ok) begin
                r_burst_d = '0;
            end else if (stream && r_done) begin
                r_burst_d = (r_burst_q == nburst - 20'd1) ? 20'd0 : r_burst_q + 20'd1;
            end
            if (pass_end_beat) begin
                run_cycles_d = run_cycles_q + 8'd1;
            end
            // In DRAIN the beat retiring the last outstanding burst closes the final pass
            if (pass_end_beat && (state_q == ST_DRAIN) && (outstanding == OUT_W'(1))) begin
                cap_done_d = 1'b1;
            end
            if (start_bad || (stream && r_hs && (axi_rresp != RESP_OKAY))) begin
                rd_err_d = 1'b1;
            end
            if (ar_hs) begin
                current_addr_d = axi_araddr;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q        <= ST_IDLE;
            r_burst_q      <= '0;
            run_cycles_q   <= '0;
            cap_done_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            current_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            r_burst_q      <= r_burst_d;
            run_cycles_q   <= run_cycles_d;
            cap_done_q     <= cap_done_d;
            rd_err_q       <= rd_err_d;
            current_addr_q <= current_addr_d;
        end
    end

    assign current_addr = current_addr_q;
    assign run_cycles   = run_cycles_q;
    assign rd_err       = rd_err_q;
    assign cap_done     = cap_done_q;
    assign busy         = state_busy(state_q);

endmodule

// File: tb/tb_axi_dma_rd.sv
// Directed bench for axi_dma_rd: an AXI read slave returning address-valued
// data, an AXIS sink, and a linear sequence of scenarios with checks.
module tb_axi_dma_rd;

    logic         clk = 1'b0;
    logic         axi_rst;
    logic [31:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic [3:0]   axi_arcache;
    logic [2:0]   axi_arprot;
    logic [3:0]   axi_arid;
    logic [3:0]   axi_aruser;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [127:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [127:0] axis_tdata;
    logic [15:0]  axis_tkeep;
    logic         axis_tlast;
    logic         axis_tvalid;
    logic         axis_tready;
    logic         read_start;
    logic         read_reset;
    logic         continuous;
    logic [31:0]  start_address;
    logic [31:0]  cap_size;
    logic [31:0]  current_addr;
    logic [7:0]   run_cycles;
    logic         rd_err;
    logic         cap_done;
    logic         busy;

    always #5 clk = ~clk;

    axi_dma_rd #(.MAX_OUTSTANDING(4), .BURST_BYTES(4096)) dut (
        .axi_aclk(clk), .axi_rst(axi_rst),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arid(axi_arid), .axi_aruser(axi_aruser),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .read_start(read_start), .read_reset(read_reset), .continuous(continuous),
        .start_address(start_address), .cap_size(cap_size),
        .current_addr(current_addr), .run_cycles(run_cycles), .rd_err(rd_err),
        .cap_done(cap_done), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Slave / monitor state
    logic [31:0] ar_log[$];
    logic [31:0] rq[$];
    int          beat = 0;
    int          gbeat = 0;
    int          err_beat = -1;
    int          ar_stall = 0;
    int          ar_allow = 1000;
    int          tready_mode = 0;
    int          beats_seen = 0;
    int          tlast_cnt = 0;
    int          stream_bad = 0;
    int          tlast_bad = 0;
    int          discard_cnt = 0;
    int          unstable = 0;
    int          mirror_bad = 0;
    int          cur_out = 0;
    int          max_out = 0;
    logic [31:0] exp_base = 32'h0;
    int          exp_beats = 1;
    int          exp_idx = 0;

    initial begin
        logic        ar_f, r_f, r_l, t_f, t_l, ar_pend;
        logic [31:0] ar_a, ar_pend_addr;
        logic [127:0] t_d, exp_d;
        int          pos;
        ar_pend = 1'b0;
        ar_pend_addr = '0;
        axi_rvalid = 1'b0; axi_rdata = '0; axi_rlast = 1'b0; axi_rresp = 2'b00;
        axi_arready = 1'b0; axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            ar_f = axi_arvalid && axi_arready; ar_a = axi_araddr;
            r_f  = axi_rvalid && axi_rready;   r_l  = axi_rlast;
            t_f  = axis_tvalid && axis_tready; t_d  = axis_tdata; t_l = axis_tlast;
            if (ar_pend && axi_arvalid && (axi_araddr != ar_pend_addr)) unstable++;
            ar_pend = axi_arvalid && !axi_arready;
            ar_pend_addr = axi_araddr;
            if (tready_mode == 1 && busy && (axi_rready !== axis_tready)) mirror_bad++;
            if (t_f) begin
                pos   = exp_idx % exp_beats;
                exp_d = {96'h0, exp_base + 32'(pos * 16)};
                if (t_d !== exp_d) stream_bad++;
                if (t_l !== (pos == exp_beats - 1)) tlast_bad++;
                if (t_l) tlast_cnt++;
                beats_seen++;
                exp_idx++;
            end
            if (r_f && !axis_tvalid) discard_cnt++;
            @(posedge clk); #1;
            if (ar_f) begin
                ar_log.push_back(ar_a);
                rq.push_back(ar_a);
                cur_out++;
            end
            if (r_f) begin
                gbeat++;
                if (r_l) begin
                    void'(rq.pop_front());
                    beat = 0;
                    cur_out--;
                end else begin
                    beat++;
                end
            end
            if (cur_out > max_out) max_out = cur_out;
            if (rq.size() > 0) begin
                axi_rvalid = 1'b1;
                axi_rdata  = {96'h0, rq[0] + 32'(beat * 16)};
                axi_rlast  = (beat == 255);
                axi_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                axi_rresp  = 2'b00;
            end
            if (ar_stall > 0) begin
                axi_arready = 1'b0;
                ar_stall--;
            end else begin
                axi_arready = (ar_log.size() < ar_allow);
            end
            case (tready_mode)
                1:       axis_tready = ~axis_tready;
                2:       axis_tready = 1'b0;
                default: axis_tready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic mon_setup(input logic [31:0] base, input int beats);
        ar_log.delete();
        beats_seen = 0; tlast_cnt = 0; stream_bad = 0; tlast_bad = 0;
        discard_cnt = 0; unstable = 0; mirror_bad = 0; max_out = cur_out;
        exp_base = base; exp_beats = beats; exp_idx = 0;
    endtask

    task automatic start_run(input logic [31:0] addr, input logic [31:0] size, input logic cont);
        start_address = addr; cap_size = size; continuous = cont;
        @(posedge clk); #2 read_start = 1'b1;
        @(posedge clk); #2 read_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_rreset();
        @(posedge clk); #2 read_reset = 1'b1;
        @(posedge clk); #2 read_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound && !cap_done; i++) @(negedge clk);
        chk(tag, 32'(cap_done), 32'd1);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    endtask

    initial begin
        axi_rst = 1'b1; read_start = 1'b0; read_reset = 1'b0; continuous = 1'b0;
        start_address = '0; cap_size = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
        chk("rst_rready", 32'(axi_rready), 32'd0);
        chk("rst_tvalid", 32'(axis_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {30'd0, cap_done, rd_err}, 32'd0);
        chk("rst_cur_addr", current_addr, 32'd0);
        chk("rst_run_cycles", 32'(run_cycles), 32'd0);
        @(posedge clk); #2 axi_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single pass, 4 bursts
        mon_setup(32'h1000_0000, 1024);
        start_run(32'h1000_0000, 32'h0000_4000, 1'b0);
        chk("t1_arlen_size", {axi_arlen, 5'd0, axi_arsize, 14'd0, axi_arburst}, {8'd255, 5'd0, 3'b100, 14'd0, 2'b01});
        chk("t1_cache_prot_id", {axi_arcache, axi_arprot, axi_arid, axi_aruser}, {4'b0011, 3'b000, 4'h0, 4'h0} );
        wait_done("t1_cap_done", 1500);
        chk("t1_ar_count", 32'(ar_log.size()), 32'd4);
        chk("t1_ar0", ar_log[0], 32'h1000_0000);
        chk("t1_ar1", ar_log[1], 32'h1000_1000);
        chk("t1_ar2", ar_log[2], 32'h1000_2000);
        chk("t1_ar3", ar_log[3], 32'h1000_3000);
        chk("t1_beats", 32'(beats_seen), 32'd1024);
        chk("t1_tlast_cnt", 32'(tlast_cnt), 32'd1);
        chk("t1_tlast_pos", 32'(tlast_bad), 32'd0);
        chk("t1_data", 32'(stream_bad), 32'd0);
        chk("t1_run_cycles", 32'(run_cycles), 32'd1);
        chk("t1_cur_addr", current_addr, 32'h1000_3000);
        chk("t1_max_out", 32'(max_out), 32'd4);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_rd_err", 32'(rd_err), 32'd0);
        pulse_rreset();
        chk("t1_clear", {22'd0, run_cycles, cap_done, rd_err}, 32'd0);
        chk("t1_clear_addr", current_addr, 32'd0);

        // AR stalled for 10 cycles at the start
        mon_setup(32'h1000_0000, 1024);
        ar_stall = 10;
        start_run(32'h1000_0abc, 32'h0000_4123, 1'b0);
        chk("t2_stall_arvalid", {31'd0, axi_arvalid}, 32'd1);
        chk("t2_stall_araddr", axi_araddr, 32'h1000_0000);
        wait_done("t2_cap_done", 1600);
        chk("t2_stable", 32'(unstable), 32'd0);
        chk("t2_max_out", 32'(max_out), 32'd4);
        chk("t2_ar3", ar_log[3], 32'h1000_3000);
        chk("t2_beats", 32'(beats_seen), 32'd1024);
        chk("t2_data", 32'(stream_bad), 32'd0);
        pulse_rreset();

        // Continuous for three passes
        mon_setup(32'h1000_0000, 1024);
        start_run(32'h1000_0000, 32'h0000_4000, 1'b1);
        for (int i = 0; i < 2000 && ar_log.size() < 9; i++) @(negedge clk);
        chk("t3_pass3_started", 32'(ar_log.size() >= 9), 32'd1);
        continuous = 1'b0;
        for (int i = 0; i < 1500 && tlast_cnt < 2; i++) @(negedge clk);
        chk("t3_tlast2", 32'(tlast_cnt), 32'd2);
        chk("t3_no_early_done", 32'(cap_done), 32'd0);
        wait_done("t3_cap_done", 1500);
        chk("t3_ar_count", 32'(ar_log.size()), 32'd12);
        chk("t3_wrap_ar4", ar_log[4], 32'h1000_0000);
        chk("t3_ar7", ar_log[7], 32'h1000_3000);
        chk("t3_wrap_ar8", ar_log[8], 32'h1000_0000);
        chk("t3_tlast_cnt", 32'(tlast_cnt), 32'd3);
        chk("t3_tlast_pos", 32'(tlast_bad), 32'd0);
        chk("t3_beats", 32'(beats_seen), 32'd3072);
        chk("t3_data", 32'(stream_bad), 32'd0);
        chk("t3_run_cycles", 32'(run_cycles), 32'd3);
        pulse_rreset();

        // tready toggling every cycle
        mon_setup(32'h2000_0000, 512);
        tready_mode = 1;
        start_run(32'h2000_0000, 32'h0000_2000, 1'b0);
        wait_done("t4_cap_done", 1500);
        chk("t4_mirror", 32'(mirror_bad), 32'd0);
        chk("t4_beats", 32'(beats_seen), 32'd512);
        chk("t4_data", 32'(stream_bad), 32'd0);
        chk("t4_tlast_cnt", 32'(tlast_cnt), 32'd1);
        tready_mode = 0;
        pulse_rreset();

        // Abort with two bursts outstanding
        mon_setup(32'h1000_0000, 1024);
        ar_allow = 2;
        tready_mode = 2;
        start_run(32'h1000_0000, 32'h0000_4000, 1'b0);
        for (int i = 0; i < 20 && ar_log.size() < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t5_cur_addr", current_addr, 32'h1000_1000);
        chk("t5_busy_run", 32'(busy), 32'd1);
        pulse_rreset();
        chk("t5_flush_busy", 32'(busy), 32'd1);
        chk("t5_flush_rready", 32'(axi_rready), 32'd1);
        chk("t5_flush_tvalid", 32'(axis_tvalid), 32'd0);
        chk("t5_flush_arvalid", 32'(axi_arvalid), 32'd0);
        chk("t5_flush_cur_addr", current_addr, 32'd0);
        for (int i = 0; i < 700 && busy; i++) @(negedge clk);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_discarded", 32'(discard_cnt), 32'd512);
        chk("t5_no_stream", 32'(beats_seen), 32'd0);
        chk("t5_status", {22'd0, run_cycles, cap_done, rd_err}, 32'd0);
        ar_allow = 1000;
        tready_mode = 0;
        repeat (2) @(negedge clk);

        // Error response on one beat, transfer continues
        mon_setup(32'h3000_0000, 256);
        err_beat = gbeat + 100;
        start_run(32'h3000_0000, 32'h0000_1000, 1'b0);
        wait_done("t6_cap_done", 500);
        chk("t6_rd_err", 32'(rd_err), 32'd1);
        chk("t6_beats", 32'(beats_seen), 32'd256);
        chk("t6_data", 32'(stream_bad), 32'd0);
        start_run(32'h4000_0000, 32'h0000_1000, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_start_in_done", {30'd0, busy, cap_done}, 32'd1);
        chk("t6_no_new_ar", 32'(ar_log.size()), 32'd1);
        pulse_rreset();
        chk("t6_err_cleared", {30'd0, cap_done, rd_err}, 32'd0);

        // read_reset beats a same-cycle read_start
        mon_setup(32'h5000_0000, 256);
        start_address = 32'h5000_0000; cap_size = 32'h0000_1000;
        @(posedge clk); #2 read_start = 1'b1; read_reset = 1'b1;
        @(posedge clk); #2 read_start = 1'b0; read_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_reset_wins", {30'd0, busy, rd_err}, 32'd0);
        chk("t7_no_ar", 32'(ar_log.size()), 32'd0);

        // Sub-burst length is rejected
        start_run(32'h6000_0000, 32'h0000_0800, 1'b0);
        chk("t8_rd_err", 32'(rd_err), 32'd1);
        repeat (5) @(negedge clk);
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_no_ar", 32'(ar_log.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
